// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and fetch constants.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NopInstrDefault = 32'h0000_0000;
  localparam logic [31:0] PcIncr          = 32'd4;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads data or a bubble when enabled, holds otherwise.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NopInstr = NopInstrDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (en_i) begin
      if (bubble_i) begin
        instr_d    = NopInstr;
        pc_plus4_d = '0;
        valid_d    = 1'b0;
      end else begin
        instr_d    = instr_i;
        pc_plus4_d = pc_plus4_i;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NopInstr;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, memory handshake FSM, skid buffer and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NopInstrDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc_D,
  input  logic [31:0] PCBranch_D,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D,
  output logic        IMemBusy_F
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  skidpc_q, skidpc_d;
  logic [31:0]  target_q, target_d;

  logic [31:0]  pc_plus4_f;
  logic         redirect;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc_plus4;

  assign pc_plus4_f = pc_q + PcIncr;
  // A stalled decode stage cannot own a branch decision yet.
  assign redirect   = PCSrc_D & ~StallD;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_d        = skid_q;
    skidpc_d      = skidpc_q;
    target_d      = target_q;
    ifid_bubble   = 1'b1;
    ifid_instr    = imem_rdata;
    ifid_pc_plus4 = pc_plus4_f;

    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          if (imem_ack) begin
            pc_d = PCBranch_D;
          end else begin
            target_d = PCBranch_D;
            state_d  = StDrain;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4_f;
          if (StallD) begin
            skid_d   = imem_rdata;
            skidpc_d = pc_plus4_f;
            state_d  = StHold;
          end else begin
            ifid_bubble = 1'b0;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = PCBranch_D;
          state_d = StFetch;
        end else if (!StallD) begin
          ifid_bubble   = 1'b0;
          ifid_instr    = skid_q;
          ifid_pc_plus4 = skidpc_q;
          state_d       = StFetch;
        end
      end
      StDrain: begin
        // The in-flight response belongs to the squashed path and is dropped.
        if (imem_ack) begin
          pc_d    = target_q;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      skid_q   <= '0;
      skidpc_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      skid_q   <= skid_d;
      skidpc_q <= skidpc_d;
      target_q <= target_d;
    end
  end

  assign imem_req   = (state_q != StHold) & ~rst;
  assign imem_addr  = pc_q;
  assign IMemBusy_F = ((state_q == StFetch) & ~imem_ack) | (state_q == StDrain);

  ifid_reg #(
    .NopInstr(NOP_INSTR)
  ) u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .en_i       (~StallD),
    .bubble_i   (ifid_bubble),
    .instr_i    (ifid_instr),
    .pc_plus4_i (ifid_pc_plus4),
    .instr_o    (Instr_D),
    .pc_plus4_o (PCPlus4_D),
    .valid_o    (Valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_fetch_stage;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc_D;
  logic [31:0] PCBranch_D;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr_D;
  logic [31:0] PCPlus4_D;
  logic        Valid_D;
  logic        IMemBusy_F;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (RstPc),
    .NOP_INSTR (Nop)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc_D    (PCSrc_D),
    .PCBranch_D (PCBranch_D),
    .StallD     (StallD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Instr_D    (Instr_D),
    .PCPlus4_D  (PCPlus4_D),
    .Valid_D    (Valid_D),
    .IMemBusy_F (IMemBusy_F)
  );

  // Reference model: PC, an optional parked response and an optional pending redirect.
  logic [31:0] m_pc, m_skid, m_skidpc, m_target;
  bit          m_holding, m_draining;
  logic [31:0] m_instr, m_pc4;
  bit          m_valid;

  task automatic model_step();
    logic [31:0] li, lp;
    bit          lv, redir;
    if (rst) begin
      m_pc = RstPc; m_holding = 0; m_draining = 0;
      m_skid = 0; m_skidpc = 0; m_target = 0;
      m_instr = Nop; m_pc4 = 0; m_valid = 0;
      chk_en = 1'b1;
      return;
    end
    li = Nop; lp = 0; lv = 0;
    redir = PCSrc_D && !StallD;
    if (m_draining) begin
      if (imem_ack) begin m_pc = m_target; m_draining = 0; end
    end else if (m_holding) begin
      if (redir) begin
        m_pc = PCBranch_D; m_holding = 0;
      end else if (!StallD) begin
        li = m_skid; lp = m_skidpc; lv = 1; m_holding = 0;
      end
    end else if (redir) begin
      if (imem_ack) m_pc = PCBranch_D;
      else begin m_target = PCBranch_D; m_draining = 1; end
    end else if (imem_ack) begin
      if (StallD) begin
        m_skid = imem_rdata; m_skidpc = m_pc + 32'd4; m_holding = 1;
      end else begin
        li = imem_rdata; lp = m_pc + 32'd4; lv = 1;
      end
      m_pc = m_pc + 32'd4;
    end
    if (!StallD) begin m_instr = li; m_pc4 = lp; m_valid = lv; end
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: inputs change on negedge, outputs settle well before the next posedge.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("m_imem_req", {31'b0, imem_req}, {31'b0, !rst && !m_holding});
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_busy", {31'b0, IMemBusy_F},
          {31'b0, m_draining || (!m_holding && !imem_ack)});
      chk("m_instr_d", Instr_D, m_instr);
      chk("m_pcplus4_d", PCPlus4_D, m_pc4);
      chk("m_valid_d", {31'b0, Valid_D}, {31'b0, m_valid});
    end
  end

  task automatic cyc(input bit r, input bit ack, input logic [31:0] rd, input bit st,
                     input bit ps, input logic [31:0] br);
    @(negedge clk);
    rst = r; imem_ack = ack; imem_rdata = rd; StallD = st; PCSrc_D = ps; PCBranch_D = br;
    #3;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 0; imem_rdata = 0; StallD = 0; PCSrc_D = 0; PCBranch_D = 0;

    // Reset and state after reset
    cyc(1, 1, 32'hBAD, 0, 0, 0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'b0, Valid_D}, 32'd0);
    chk("rst_instr", Instr_D, Nop);
    chk("rst_pc4", PCPlus4_D, 32'd0);
    chk("rst_addr", imem_addr, RstPc);

    // Back-to-back acks with rdata = PC
    cyc(0, 1, 32'h0, 0, 0, 0);
    cyc(0, 1, 32'h4, 0, 0, 0);
    chk("seq_instr0", Instr_D, 32'h0);
    chk("seq_pc4_0", PCPlus4_D, 32'h4);
    chk("seq_addr4", imem_addr, 32'h4);
    cyc(0, 1, 32'h8, 0, 0, 0);
    chk("seq_instr4", Instr_D, 32'h4);
    chk("seq_valid", {31'b0, Valid_D}, 32'd1);

    // Three-cycle ack delay
    cyc(0, 0, 0, 0, 0, 0);
    chk("dly_instr8", Instr_D, 32'h8);
    chk("dly_busy", {31'b0, IMemBusy_F}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("dly_bubble", {31'b0, Valid_D}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("dly_addr", imem_addr, 32'hC);
    cyc(0, 1, 32'h1234, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("dly_instr", Instr_D, 32'h1234);
    chk("dly_pc4", PCPlus4_D, 32'h10);

    // Stall during ack parks the word in the skid buffer
    cyc(0, 1, 32'hAABB, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hold_instr", Instr_D, 32'hAABB);
    chk("hold_pc4", PCPlus4_D, 32'h14);
    chk("hold_addr", imem_addr, 32'h14);

    // Redirect with ack pending drains the old request
    cyc(0, 0, 0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_busy", {31'b0, IMemBusy_F}, 32'd1);
    cyc(0, 1, 32'hDEAD, 0, 1, 32'h200);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_addr", imem_addr, 32'h100);
    chk("drain_valid", {31'b0, Valid_D}, 32'd0);

    // PC wrap
    cyc(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 1, 32'h55, 0, 0, 0);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_pc4", PCPlus4_D, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset while draining
    cyc(0, 0, 0, 0, 1, 32'h300);
    cyc(1, 1, 32'hBAD, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rstd_addr", imem_addr, RstPc);
    chk("rstd_valid", {31'b0, Valid_D}, 32'd0);
    cyc(0, 1, 32'h77, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rstd_instr", Instr_D, 32'h77);
    chk("rstd_pc4", PCPlus4_D, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] br;
      br = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 7) == 0) br = 32'hFFFF_FFF8 + {$urandom_range(0, 1), 2'b00};
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, $urandom,
          $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 15, br);
    end

    cyc(0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
